// File: rtl/secuenciador_pkg.sv
// Shared codes for the slice sequencer: sumador opcodes, external op codes and FSM states.
package secuenciador_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_AND = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b10;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input op_e o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

  // SUB reuses the adder: the B nibble is inverted and slice 0 gets Cin=1.
  function automatic logic [1:0] aluop_of(input op_e o);
    case (o)
      OP_AND:  return ALUOP_AND;
      OP_OR:   return ALUOP_OR;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/sumador.sv
// 4-bit ALU slice shared by several masters: add with carry, or bitwise AND/OR.
import secuenciador_pkg::*;

module sumador (
  input  logic [3:0] op1,
  input  logic [3:0] op2,
  input  logic [1:0] aluop,
  input  logic       l,
  input  logic       cin0,
  output logic [3:0] r,
  output logic       cout3
);

  logic [4:0] sum;

  always_comb begin
    sum   = {1'b0, op1} + {1'b0, op2} + {4'b0, cin0};
    r     = 4'h0;
    cout3 = 1'b0;
    if (!l) begin
      r     = sum[3:0];
      cout3 = sum[4];
    end else begin
      case (aluop)
        ALUOP_AND: r = op1 & op2;
        ALUOP_OR:  r = op1 | op2;
        default:   r = 4'h0;
      endcase
    end
  end

endmodule

// File: rtl/secuenciador_suma.sv
// Runs a W-bit ADD/SUB/AND/OR one nibble per cycle on the external sumador slice,
// chaining the slice carry through a register and collecting result and flags.
import secuenciador_pkg::*;

module secuenciador_suma #(
  parameter int NSLICES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [4*NSLICES-1:0] a,
  input  logic [4*NSLICES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NSLICES-1:0] result,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_v,
  output logic [3:0]           alu_op1,
  output logic [3:0]           alu_op2,
  output logic [1:0]           alu_aluop,
  output logic                 alu_l,
  output logic                 alu_cin,
  input  logic [3:0]           alu_r,
  input  logic                 alu_cout
);

  localparam int W  = 4 * NSLICES;
  localparam int SW = $clog2(NSLICES);
  localparam logic [SW-1:0] LAST = SW'(NSLICES - 1);

  state_e        state;
  logic [SW-1:0] slice;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  op_e           op_q;
  logic [W-1:0]  b_eff;
  logic [W-1:0]  full_r;

  assign b_eff  = (op_q == OP_SUB) ? ~b_q : b_q;
  // Result as it stands once the current (last) nibble lands.
  assign full_r = {alu_r, result[W-5:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      slice  <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_e'(op);
            slice <= '0;
            carry <= (op == OP_SUB);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[{slice, 2'b00} +: 4] <= alu_r;
          // Logic ops keep the carry register parked at 0.
          if (is_arith(op_q)) carry <= alu_cout;
          if (slice == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            slice  <= '0;
            flag_z <= (full_r == '0);
            flag_c <= is_arith(op_q) && alu_cout;
            flag_v <= is_arith(op_q) && (a_q[W-1] == b_eff[W-1])
                                     && (alu_r[3] != a_q[W-1]);
          end else begin
            slice <= slice + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slice drive is only active in RUN so the sumador is free otherwise.
  always_comb begin
    alu_op1   = 4'h0;
    alu_op2   = 4'h0;
    alu_aluop = 2'b00;
    alu_l     = 1'b0;
    alu_cin   = 1'b0;
    if (state == RUN) begin
      alu_op1   = a_q[{slice, 2'b00} +: 4];
      alu_op2   = b_eff[{slice, 2'b00} +: 4];
      alu_aluop = aluop_of(op_q);
      alu_l     = !is_arith(op_q);
      alu_cin   = carry;
    end
  end

endmodule

// File: tb/tb_secuenciador_suma.sv
// Directed bench: secuenciador_suma driving a real sumador slice, NSLICES=4.
module tb_secuenciador_suma;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, flag_c, flag_z, flag_v;
  logic [15:0] result;
  logic [3:0]  alu_op1, alu_op2, alu_r;
  logic [1:0]  alu_aluop;
  logic        alu_l, alu_cin, alu_cout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  secuenciador_suma #(.NSLICES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
    .alu_l(alu_l), .alu_cin(alu_cin), .alu_r(alu_r), .alu_cout(alu_cout)
  );

  sumador alu (
    .op1(alu_op1), .op2(alu_op2), .aluop(alu_aluop), .l(alu_l),
    .cin0(alu_cin), .r(alu_r), .cout3(alu_cout)
  );

  // Stimulus only: launches one op and waits (bounded) for done, sampling on negedges.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat, output int busy_cnt, output int l_cnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0; l_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (busy && alu_l) l_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, result, flag_c, flag_z, flag_v} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h c=%b z=%b v=%b expected all 0",
               busy, done, result, flag_c, flag_z, flag_v);
    end
    vectors++;
    if ({alu_op1, alu_op2, alu_aluop, alu_l, alu_cin} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_alu: got %h expected 000", {alu_op1, alu_op2, alu_aluop, alu_l, alu_cin});
    end
    reset = 1'b0;
  endtask

  task automatic test_arith(input string name, input logic [1:0] o, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] er,
                            input logic ec, input logic ez, input logic ev);
    int lat, bc, lc;
    do_op(o, x, y, lat, bc, lc);
    vectors++;
    if (lat !== 5 || bc !== 4) begin
      miscompares++;
      $display("FAIL %s_latency: got done@%0d busy_cycles=%0d expected done@5 busy_cycles=4", name, lat, bc);
    end
    vectors++;
    if (result !== er) begin
      miscompares++;
      $display("FAIL %s_result: got %h expected %h", name, result, er);
    end
    vectors++;
    if ({flag_c, flag_z, flag_v} !== {ec, ez, ev}) begin
      miscompares++;
      $display("FAIL %s_flags: got czv=%b%b%b expected %b%b%b", name, flag_c, flag_z, flag_v, ec, ez, ev);
    end
    vectors++;
    if (lc !== 0) begin
      miscompares++;
      $display("FAIL %s_alu_l: got %0d logic cycles expected 0", name, lc);
    end
  endtask

  task automatic test_logic(input string name, input logic [1:0] o, input logic [15:0] er);
    int lat, bc, lc;
    do_op(o, 16'hF0F0, 16'h3C3C, lat, bc, lc);
    vectors++;
    if (result !== er || lat !== 5) begin
      miscompares++;
      $display("FAIL %s_result: got %h done@%0d expected %h done@5", name, result, lat, er);
    end
    vectors++;
    if ({flag_c, flag_z, flag_v} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_flags: got czv=%b%b%b expected 000", name, flag_c, flag_z, flag_v);
    end
    vectors++;
    if (lc !== 4) begin
      miscompares++;
      $display("FAIL %s_alu_l: got %0d logic cycles expected 4", name, lc);
    end
  endtask

  task automatic test_start_mid_run();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0FFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (result !== 16'h2233 || lat !== 5) begin
      miscompares++;
      $display("FAIL start_mid_run: got %h done@%0d expected 2233 done@5", result, lat);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_mid_run_queued: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, lc;
    do_op(2'b00, 16'h0001, 16'h0001, lat, bc, lc);
    vectors++;
    if (result !== 16'h0002 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h done=%b expected 0002 done=1", result, done);
    end
    start = 1'b1; op = 2'b01; a = 16'h0010; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (result !== 16'h000F || {flag_c, flag_z, flag_v} !== 3'b100 || lat !== 5) begin
      miscompares++;
      $display("FAIL b2b_second: got %h czv=%b%b%b done@%0d expected 000f czv=100 done@5",
               result, flag_c, flag_z, flag_v, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0FFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({busy, done, result, flag_c, flag_z, flag_v} !== 21'h0 ||
        {alu_op1, alu_op2, alu_aluop, alu_l, alu_cin} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got busy=%b done=%b result=%h alu=%h expected all 0",
               busy, done, result, {alu_op1, alu_op2, alu_aluop, alu_l, alu_cin});
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_run_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_arith("add_basic", 2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
    test_arith("add_ripple", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    test_arith("sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    test_arith("sub_borrow", 2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    test_logic("and", 2'b10, 16'h3030);
    test_logic("or", 2'b11, 16'hFCFC);
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
